tff_reg_arbiter: RTL and testbench

Arbitrated write controller for a WIDTH-bit register built purely from T flip-flops. Two requesters issue LOAD (D-style write) or TOGGLE operations. The block grants them round-robin and sequences each grant through a fixed three-state FSM. For a LOAD it converts the request into a toggle mask against the current register value, which is the D-from-T conversion applied to a whole shared register.

---
 rtl/tff_arb_pkg.sv | 35 +++
 rtl/tff_bank.sv | 32 +++
 rtl/tff_reg_arbiter.sv | 151 +++++++++++++++
 tb/tb_tff_reg_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tff_arb_pkg.sv
// -----------------------------------------------------------------------------
// tff_arb_pkg
// Shared definitions for the T-flip-flop register arbiter:
//   - state_t   : FSM state encodings (2'd3 is unused and recovers to IDLE)
//   - OP_LOAD / OP_TOGGLE : operation codes carried on op0/op1
//   - winner_sel: round-robin pick between two requesters
// -----------------------------------------------------------------------------
package tff_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_TOGGLE = 1'b1;

    // Returns the index of the winning requester. With both requesting, the
    // pointer decides; a lone requester wins regardless of the pointer.
    function automatic logic winner_sel(input logic req_a,
                                        input logic req_b,
                                        input logic ptr);
        logic w_sel;
        if (req_a && req_b) begin
            w_sel = ptr;
        end else if (req_b) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// -----------------------------------------------------------------------------
// tff_bank
// WIDTH T flip-flops: each bit inverts when its t bit is high.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset, clears all bits
//   t   : per-bit toggle enable
//   q   : register contents (registered)
// -----------------------------------------------------------------------------
module tff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // T flip-flop array: q toggles where t is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= {WIDTH{1'b0}};
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tff_reg_arbiter
// Two-requester round-robin write controller for a register built from T
// flip-flops. Each grant runs IDLE -> APPLY -> ACK. A LOAD is turned into a
// toggle mask (data ^ q) so the T-flop bank ends up holding the loaded value.
// Ports:
//   clk                : rising-edge clock
//   rst                : synchronous active-low reset
//   req0/op0/data0     : requester 0 level request, op (0 LOAD, 1 TOGGLE), operand
//   req1/op1/data1     : requester 1, same meaning
//   ack0/ack1          : one-cycle completion pulse to the served requester
//   grant              : one-hot owner (bit0 = requester 0), 2'b00 when idle
//   busy               : high whenever the FSM is not IDLE
//   q                  : shared register contents
// All outputs are registered.
// -----------------------------------------------------------------------------
module tff_reg_arbiter
    import tff_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    state_t           r_state;
    logic             r_ptr;
    logic             r_win;
    logic             r_op;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_grant;
    logic             r_busy;
    logic             r_ack0;
    logic             r_ack1;

    state_t           w_state_nxt;
    logic             w_ptr_nxt;
    logic             w_win_nxt;
    logic             w_op_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic [1:0]       w_grant_nxt;
    logic             w_busy_nxt;
    logic             w_ack0_nxt;
    logic             w_ack1_nxt;
    logic [WIDTH-1:0] w_t;
    logic             w_pick;
    logic [WIDTH-1:0] w_q;

    assign w_pick = winner_sel(req0, req1, r_ptr);

    // Next-state, operand latch, output and toggle-mask logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_t         = {WIDTH{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_win_nxt   = w_pick;
                    w_op_nxt    = w_pick ? op1 : op0;
                    w_data_nxt  = w_pick ? data1 : data0;
                    w_grant_nxt = w_pick ? 2'b10 : 2'b01;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_APPLY;
                end else begin
                    w_grant_nxt = 2'b00;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_APPLY: begin
                // LOAD flips exactly the bits that differ from the target.
                w_t         = (r_op == OP_LOAD) ? (r_data ^ w_q) : r_data;
                w_ack0_nxt  = ~r_win;
                w_ack1_nxt  = r_win;
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                // The loser gets priority on the next collision.
                w_ptr_nxt   = ~r_win;
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer, operand latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_win   <= 1'b0;
            r_op    <= OP_LOAD;
            r_data  <= {WIDTH{1'b0}};
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_op    <= w_op_nxt;
            r_data  <= w_data_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
        end
    end

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .t   (w_t),
        .q   (w_q)
    );

    assign q     = w_q;
    assign grant = r_grant;
    assign busy  = r_busy;
    assign ack0  = r_ack0;
    assign ack1  = r_ack1;

endmodule

// File: tb/tb_tff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tff_reg_arbiter
// Directed bench for tff_reg_arbiter (WIDTH = 8). Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, so each step below
// shows the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_tff_reg_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       op0;
    logic [7:0] data0;
    logic       req1;
    logic       op1;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic [1:0] grant;
    logic       busy;
    logic [7:0] q;

    int checks   = 0;
    int failures = 0;

    tff_reg_arbiter #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .op0   (op0),
        .data0 (data0),
        .req1  (req1),
        .op1   (op1),
        .data1 (data1),
        .ack0  (ack0),
        .ack1  (ack1),
        .grant (grant),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic b,
                              input logic a0, input logic a1, input logic [7:0] qv);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".ack0"},  32'(ack0),  32'(a0));
        check({tag, ".ack1"},  32'(ack1),  32'(a1));
        check({tag, ".q"},     32'(q),     32'(qv));
    endtask

    logic [1:0] bb_grant [6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    logic       bb_busy  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       bb_ack0  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] bb_q     [6] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};

    initial begin
        // Reset held two cycles with requester 0 already asking for LOAD A5.
        rst = 1'b0; req0 = 1'b1; op0 = 1'b0; data0 = 8'hA5;
        req1 = 1'b0; op1 = 1'b0; data1 = 8'h00;
        tick();
        tick();
        expect_out("reset", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        expect_out("load_e0", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        expect_out("load_e1", 2'b01, 1'b1, 1'b1, 1'b0, 8'hA5);
        // Requester 1 raises TOGGLE 0F while the block is still in ACK.
        req0 = 1'b0;
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h0F;
        tick();
        expect_out("load_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'hA5);
        tick();
        expect_out("tog_e0", 2'b10, 1'b1, 1'b0, 1'b0, 8'hA5);
        // Operands are latched: these changes must not affect this op.
        req1 = 1'b0; op1 = 1'b0; data1 = 8'hFF;
        tick();
        expect_out("tog_e1", 2'b10, 1'b1, 1'b0, 1'b1, 8'hAA);
        // LOAD of the value already held.
        req1 = 1'b1; op1 = 1'b0; data1 = 8'hAA;
        tick();
        expect_out("tog_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'hAA);
        tick();
        expect_out("same_e0", 2'b10, 1'b1, 1'b0, 1'b0, 8'hAA);
        tick();
        expect_out("same_e1", 2'b10, 1'b1, 1'b0, 1'b1, 8'hAA);
        req1 = 1'b0;
        tick();
        expect_out("same_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'hAA);

        // Contention from reset: order must be 0, 1, 0, 1.
        rst = 1'b0;
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h11;
        req1 = 1'b1; op1 = 1'b0; data1 = 8'h22;
        tick();
        expect_out("con_rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        expect_out("con_a_e0", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        expect_out("con_a_e1", 2'b01, 1'b1, 1'b1, 1'b0, 8'h11);
        data0 = 8'h33;
        tick();
        expect_out("con_a_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'h11);
        tick();
        expect_out("con_b_e3", 2'b10, 1'b1, 1'b0, 1'b0, 8'h11);
        data1 = 8'h44;
        tick();
        expect_out("con_b_e4", 2'b10, 1'b1, 1'b0, 1'b1, 8'h22);
        tick();
        expect_out("con_b_e5", 2'b00, 1'b0, 1'b0, 1'b0, 8'h22);
        tick();
        expect_out("con_c_e0", 2'b01, 1'b1, 1'b0, 1'b0, 8'h22);
        tick();
        expect_out("con_c_e1", 2'b01, 1'b1, 1'b1, 1'b0, 8'h33);
        req0 = 1'b0;
        tick();
        expect_out("con_c_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'h33);
        tick();
        expect_out("con_d_e0", 2'b10, 1'b1, 1'b0, 1'b0, 8'h33);
        tick();
        expect_out("con_d_e1", 2'b10, 1'b1, 1'b0, 1'b1, 8'h44);
        req1 = 1'b0;
        tick();
        expect_out("con_d_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'h44);

        // Reset during APPLY aborts the op with no ack.
        req0 = 1'b1; op0 = 1'b1; data0 = 8'h0F;
        tick();
        expect_out("abort_e0", 2'b01, 1'b1, 1'b0, 1'b0, 8'h44);
        rst = 1'b0; op0 = 1'b0; data0 = 8'h5A;
        tick();
        expect_out("abort_rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        expect_out("after_e0", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        expect_out("after_e1", 2'b01, 1'b1, 1'b1, 1'b0, 8'h5A);
        req0 = 1'b0;
        tick();
        expect_out("after_e2", 2'b00, 1'b0, 1'b0, 1'b0, 8'h5A);

        // Back-to-back TOGGLE FF with req0 held for six cycles.
        rst = 1'b0;
        tick();
        expect_out("bb_rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1; req0 = 1'b1; op0 = 1'b1; data0 = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out($sformatf("bb_c%0d", i), bb_grant[i], bb_busy[i],
                       bb_ack0[i], 1'b0, bb_q[i]);
        end
        req0 = 1'b0;
        tick();
        expect_out("bb_end", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
